tdm_slice_serializer: RTL and testbench

- Parametrised time-division multiplexer for the mic array. Takes one frame of NUM_CH parallel PCM samples and emits them on a narrow bus, one SLICE_W-bit slice per clock.
- Slices go out MSB-first, channel 0 first. Each slice is tagged with its channel index and start/end-of-frame markers.
- Successor to the fixed 2-channel / 4-bit-slice multiplexer. Adds an input handshake, a one-frame pending buffer for gapless back-to-back frames, and overrun detection.
- Sits between the per-mic decimation/PCM stage and the narrow off-chip or inter-block link.

---
 rtl/mic_array_pkg.sv | 35 +++
 rtl/tdm_frame_buffer.sv | 99 +++++++++
 rtl/tdm_slice_serializer.sv | 182 ++++++++++++++++++
 tb/tb_tdm_slice_serializer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_array_pkg.sv
// -----------------------------------------------------------------------------
// mic_array_pkg
//   Shared definitions for the mic-array TDM slice serializer.
//   - DEF_NUM_CH / DEF_SAMPLE_W / DEF_SLICE_W : default array geometry
//   - tdm_state_e : serializer FSM states (IDLE, SEND)
//   - slice_lsb() : bit position, inside a packed frame, of the LSB of the
//                   slice emitted at a given frame index (MSB-first within a
//                   channel, channel 0 first).
// -----------------------------------------------------------------------------
package mic_array_pkg;

   localparam int DEF_NUM_CH   = 2;
   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_SLICE_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tdm_state_e;

   // Frame index idx selects channel idx/slices and slice idx%slices of that
   // channel. Slice 0 is the most significant SLICE_W bits of the sample, so
   // its LSB sits slice_w below the top of the channel field.
   function automatic int slice_lsb(input int idx,
                                    input int slices,
                                    input int sample_w,
                                    input int slice_w);
      int ch;
      int s;
      ch = idx / slices;
      s  = idx % slices;
      return ch * sample_w + sample_w - (s + 1) * slice_w;
   endfunction

endpackage : mic_array_pkg

// File: rtl/tdm_frame_buffer.sv
// -----------------------------------------------------------------------------
// tdm_frame_buffer
//   Frame storage for the serializer: an active frame (being emitted) and a
//   one-deep pending frame (waiting), plus the input handshake and the sticky
//   overrun flag.
//
//   Handshake: a frame transfers on a rising edge where in_valid_i and
//   in_ready_o are both 1. in_ready_o depends only on registered state (the
//   pending slot being free), never on in_valid_i in the same cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_data_i       packed frame offered by the producer
//   in_valid_i      frame offered this cycle
//   in_ready_o      pending slot free, an offered frame will be accepted
//   sending_i       serializer is in SEND
//   frame_end_i     serializer is emitting the last slice this edge
//   overrun_clr_i   clears the sticky overrun flag
//   accept_o        handshake completes on this edge
//   active_o        frame currently being emitted
//   overrun_o       sticky: a frame was offered while in_ready_o was 0
// -----------------------------------------------------------------------------
module tdm_frame_buffer #(
   parameter int FRAME_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               sending_i,
   input  logic               frame_end_i,
   input  logic               overrun_clr_i,
   output logic               accept_o,
   output logic [FRAME_W-1:0] active_o,
   output logic               overrun_o
);

   logic [FRAME_W-1:0] active_q, active_d;
   logic [FRAME_W-1:0] pend_q, pend_d;
   logic               pend_full_q, pend_full_d;
   logic               overrun_q, overrun_d;

   assign in_ready_o = !pend_full_q;
   assign accept_o   = in_valid_i && !pend_full_q;
   assign active_o   = active_q;
   assign overrun_o  = overrun_q;

   always_comb begin
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;

      if (!sending_i) begin
         // Idle: a new frame goes straight to active, pending stays free.
         if (accept_o) begin
            active_d = in_data_i;
         end
      end else if (frame_end_i) begin
         // Last slice leaves this edge. A waiting frame takes over; otherwise
         // a frame arriving right now is treated as if it had been waiting,
         // so either way the next edge emits slice 0 with no bubble. Both
         // cannot happen together because a full pending blocks accept_o.
         if (pend_full_q) begin
            active_d    = pend_q;
            pend_d      = '0;
            pend_full_d = 1'b0;
         end else if (accept_o) begin
            active_d = in_data_i;
         end
      end else if (accept_o) begin
         pend_d      = in_data_i;
         pend_full_d = 1'b1;
      end

      // Set has priority over clear so a coincident overrun is never lost.
      overrun_d = overrun_q;
      if (in_valid_i && !in_ready_o) begin
         overrun_d = 1'b1;
      end else if (overrun_clr_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule : tdm_frame_buffer

// File: rtl/tdm_slice_serializer.sv
// -----------------------------------------------------------------------------
// tdm_slice_serializer
//   Takes a frame of NUM_CH parallel PCM samples and emits it on a narrow bus,
//   one SLICE_W-bit slice per clock, channel 0 first, MSB slice first. Each
//   slice carries its channel index and start/end-of-frame markers. A one
//   frame pending buffer allows gapless back-to-back frames; frames offered
//   while that buffer is full are dropped and flagged on the sticky overrun.
//
//   Handshake: in_data/in_valid transfer on a rising edge with in_ready=1.
//   in_ready is driven from registers only. The output side has no
//   backpressure: out_valid marks each cycle that carries a slice.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   in_data      packed frame, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   in_valid     frame offered this cycle
//   in_ready     frame will be accepted (pending slot free)
//   out_valid    out_slice holds a valid slice
//   out_slice    current slice
//   out_ch       channel index of the current slice
//   out_sof      first slice of a frame
//   out_eof      last slice of a frame
//   overrun      sticky: a frame was offered while in_ready=0
//   overrun_clr  clears overrun (a coincident new overrun wins)
// -----------------------------------------------------------------------------
module tdm_slice_serializer
   import mic_array_pkg::*;
#(
   parameter  int NUM_CH   = DEF_NUM_CH,
   parameter  int SAMPLE_W = DEF_SAMPLE_W,
   parameter  int SLICE_W  = DEF_SLICE_W,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int FRAME_W  = NUM_CH * SAMPLE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               out_valid,
   output logic [SLICE_W-1:0] out_slice,
   output logic [CH_W-1:0]    out_ch,
   output logic               out_sof,
   output logic               out_eof,
   output logic               overrun,
   input  logic               overrun_clr
);

   localparam int SLICES    = SAMPLE_W / SLICE_W;
   localparam int FRAME_LEN = NUM_CH * SLICES;
   localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   // Geometry checks at elaboration.
   if (SAMPLE_W % SLICE_W != 0) begin : g_bad_slice_w
      $error("tdm_slice_serializer: SAMPLE_W (%0d) must be a multiple of SLICE_W (%0d)",
             SAMPLE_W, SLICE_W);
   end
   if (NUM_CH < 2) begin : g_bad_num_ch
      $error("tdm_slice_serializer: NUM_CH (%0d) must be at least 2", NUM_CH);
   end

   tdm_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic               out_valid_q, out_valid_d;
   logic [SLICE_W-1:0] out_slice_q, out_slice_d;
   logic [CH_W-1:0]    out_ch_q, out_ch_d;
   logic               out_sof_q, out_sof_d;
   logic               out_eof_q, out_eof_d;

   logic               sending;
   logic               frame_end;
   logic               accept;
   logic [FRAME_W-1:0] active;

   assign sending   = (state_q == ST_SEND);
   assign frame_end = sending && (idx_q == IDX_W'(FRAME_LEN - 1));

   tdm_frame_buffer #(
      .FRAME_W (FRAME_W)
   ) u_buf (
      .clk           (clk),
      .rst           (rst),
      .in_data_i     (in_data),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .sending_i     (sending),
      .frame_end_i   (frame_end),
      .overrun_clr_i (overrun_clr),
      .accept_o      (accept),
      .active_o      (active),
      .overrun_o     (overrun)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // Stay in SEND across a frame boundary whenever another frame is
            // ready (waiting in pending or arriving on this very edge).
            if (frame_end && !in_ready) begin
               state_d = ST_SEND;
            end else if (frame_end && !accept) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The counter only ever wraps through this explicit reload; in IDLE it
      // rests at 0 so the first SEND edge emits slice 0.
      if (sending && !frame_end) begin
         idx_d = IDX_W'(int'(idx_q) + 1);
      end else begin
         idx_d = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Output decode: in SEND, slice idx of the active frame is registered
   // onto the outputs on the next edge. Outside SEND everything reads 0.
   // ---------------------------------------------------------------------
   always_comb begin
      out_valid_d = 1'b0;
      out_slice_d = '0;
      out_ch_d    = '0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      if (sending) begin
         out_valid_d = 1'b1;
         out_slice_d = SLICE_W'(active >> slice_lsb(int'(idx_q), SLICES, SAMPLE_W, SLICE_W));
         out_ch_d    = CH_W'(int'(idx_q) / SLICES);
         out_sof_d   = (idx_q == '0);
         out_eof_d   = frame_end;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_slice_q <= '0;
         out_ch_q    <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_slice_q <= out_slice_d;
         out_ch_q    <= out_ch_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_slice = out_slice_q;
   assign out_ch    = out_ch_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;

endmodule : tdm_slice_serializer

// File: tb/tb_tdm_slice_serializer.sv
// -----------------------------------------------------------------------------
// Bench for tdm_slice_serializer.
//   u0: default geometry (2 ch x 16 bit, 4-bit slices), compared every
//       negedge against a frame-queue model plus directed literal checks.
//   u1: 4 ch x 24 bit, 8-bit slices, directed literal checks only.
// -----------------------------------------------------------------------------
module tb_tdm_slice_serializer;

   // u0 geometry
   localparam int NC = 2;
   localparam int SW = 16;
   localparam int LW = 4;
   localparam int SL = SW / LW;
   localparam int FL = NC * SL;
   localparam int FW = NC * SW;

   // u1 geometry
   localparam int FW1 = 4 * 24;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------
   logic [FW-1:0] in_data     = '0;
   logic          in_valid    = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [LW-1:0] out_slice;
   logic [0:0]    out_ch;
   logic          out_sof;
   logic          out_eof;
   logic          overrun;
   logic          overrun_clr = 1'b0;

   logic [FW1-1:0] u1_in_data     = '0;
   logic           u1_in_valid    = 1'b0;
   logic           u1_in_ready;
   logic           u1_out_valid;
   logic [7:0]     u1_out_slice;
   logic [1:0]     u1_out_ch;
   logic           u1_out_sof;
   logic           u1_out_eof;
   logic           u1_overrun;
   logic           u1_overrun_clr = 1'b0;

   tdm_slice_serializer u0 (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_slice   (out_slice),
      .out_ch      (out_ch),
      .out_sof     (out_sof),
      .out_eof     (out_eof),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   tdm_slice_serializer #(
      .NUM_CH   (4),
      .SAMPLE_W (24),
      .SLICE_W  (8)
   ) u1 (
      .clk         (clk),
      .rst         (rst),
      .in_data     (u1_in_data),
      .in_valid    (u1_in_valid),
      .in_ready    (u1_in_ready),
      .out_valid   (u1_out_valid),
      .out_slice   (u1_out_slice),
      .out_ch      (u1_out_ch),
      .out_sof     (u1_out_sof),
      .out_eof     (u1_out_eof),
      .overrun     (u1_overrun),
      .overrun_clr (u1_overrun_clr)
   );

   // ---------------------------------------------------------------------
   // Counters and check helper
   // ---------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model for u0: a queue of accepted frames not yet fully sent.
   // Head is the frame on the wire, a second entry is the waiting frame, so
   // the design can take a new frame whenever fewer than two are held.
   // ---------------------------------------------------------------------
   logic [FW-1:0] exp_q[$];
   int            pos = 0;
   logic          exp_valid = 1'b0;
   logic [LW-1:0] exp_slice = '0;
   logic [0:0]    exp_ch    = '0;
   logic          exp_sof   = 1'b0;
   logic          exp_eof   = 1'b0;
   logic          exp_ovr   = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         pos       = 0;
         exp_valid = 1'b0;
         exp_slice = '0;
         exp_ch    = '0;
         exp_sof   = 1'b0;
         exp_eof   = 1'b0;
         exp_ovr   = 1'b0;
      end else begin
         automatic bit            can_take = (exp_q.size() < 2);
         automatic logic [FW-1:0] f;
         automatic logic [FW-1:0] shifted;
         automatic int            c;
         automatic int            s;
         if (exp_q.size() > 0) begin
            f         = exp_q[0];
            c         = pos / SL;
            s         = pos % SL;
            shifted   = f >> (c * SW + (SW - (s + 1) * LW));
            exp_valid = 1'b1;
            exp_slice = shifted[LW-1:0];
            exp_ch    = c[0:0];
            exp_sof   = (pos == 0);
            exp_eof   = (pos == FL - 1);
            pos++;
            if (pos == FL) begin
               void'(exp_q.pop_front());
               pos = 0;
            end
         end else begin
            exp_valid = 1'b0;
            exp_slice = '0;
            exp_ch    = '0;
            exp_sof   = 1'b0;
            exp_eof   = 1'b0;
         end
         if (in_valid && can_take) exp_q.push_back(in_data);
         if (in_valid && !can_take) exp_ovr = 1'b1;
         else if (overrun_clr)      exp_ovr = 1'b0;
      end
   end

   // Compare process: every negedge, outputs are registered and stable.
   always @(negedge clk) begin
      chk("cmp_in_ready", in_ready, (exp_q.size() < 2));
      chk("cmp_overrun", overrun, exp_ovr);
      chk("cmp_out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         chk("cmp_out_slice", out_slice, exp_slice);
         chk("cmp_out_ch", out_ch, exp_ch);
         chk("cmp_out_sof", out_sof, exp_sof);
         chk("cmp_out_eof", out_eof, exp_eof);
      end
   end

   // ---------------------------------------------------------------------
   // Driver helpers: tick() advances to the next negedge and tracks the
   // length of the out_valid burst and any gap inside it.
   // ---------------------------------------------------------------------
   int vcount    = 0;
   int gaps      = 0;
   bit seen_drop = 0;

   task automatic clear_counts();
      vcount    = 0;
      gaps      = 0;
      seen_drop = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      if (out_valid) begin
         vcount++;
         if (seen_drop) gaps++;
      end else if (vcount > 0) begin
         seen_drop = 1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (!(seen_drop && !out_valid) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL %s: burst did not end within 200 cycles (count=%0d)", name, vcount);
      end
      tick();
      tick();
   endtask

   logic [3:0] t1_s [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
   logic [7:0] t5_s [12] = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00,
                             8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56};

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_overrun", overrun, 0);
      chk("rst_out_slice", out_slice, 0);
      rst = 1'b0;
      tick();
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_valid", out_valid, 0);

      // T1: single frame, literal expectations
      in_data  = {16'h1234, 16'hABCD};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t1_latency_valid", out_valid, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t1_valid", out_valid, 1);
         chk("t1_slice", out_slice, t1_s[i]);
         chk("t1_ch", out_ch, (i / 4));
         chk("t1_sof", out_sof, (i == 0));
         chk("t1_eof", out_eof, (i == 7));
      end
      tick();
      chk("t1_after_valid", out_valid, 0);
      tick();

      // T2: second frame offered mid-emission -> 16 contiguous slices
      clear_counts();
      in_data  = {16'h5A5A, 16'h0F0F};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      in_data  = {16'hC3C3, 16'h9876};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      drain("t2_drain");
      chk("t2_len", vcount, 16);
      chk("t2_gaps", gaps, 0);

      // T3: overrun with pending full, clear, and set-wins-over-clear
      clear_counts();
      in_data  = {16'h1111, 16'h2222};
      in_valid = 1'b1;
      tick();
      in_data  = {16'h3333, 16'h4444};
      tick();
      chk("t3_ready_full", in_ready, 0);
      in_data  = {16'hDEAD, 16'hBEEF};
      tick();
      in_valid = 1'b0;
      chk("t3_overrun_set", overrun, 1);
      overrun_clr = 1'b1;
      tick();
      chk("t3_overrun_clr", overrun, 0);
      chk("t3_ready_still_full", in_ready, 0);
      in_valid = 1'b1;
      tick();
      in_valid    = 1'b0;
      overrun_clr = 1'b0;
      chk("t3_set_wins", overrun, 1);
      drain("t3_drain");
      chk("t3_len", vcount, 16);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      tick();

      // T4: asynchronous reset at slice 3 with pending full
      in_data  = {16'h7777, 16'h8888};
      in_valid = 1'b1;
      tick();
      in_data  = {16'h9999, 16'hAAAA};
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("t4_pre_slice3", out_slice, 4'h8);
      #2 rst = 1'b1;
      #1;
      chk("t4_rst_valid", out_valid, 0);
      chk("t4_rst_slice", out_slice, 0);
      chk("t4_rst_sof", out_sof, 0);
      chk("t4_rst_eof", out_eof, 0);
      chk("t4_rst_ready", in_ready, 1);
      tick();
      tick();
      rst = 1'b0;
      clear_counts();
      repeat (20) tick();
      chk("t4_no_resume", vcount, 0);
      chk("t4_ready_after", in_ready, 1);

      // Randomized traffic, two offer densities
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 300; i++) begin
            tick();
            in_valid    = ($urandom_range(0, 99) < (ph == 0 ? 12 : 60));
            in_data     = $urandom;
            overrun_clr = ($urandom_range(0, 19) == 0);
         end
      end
      in_valid    = 1'b0;
      overrun_clr = 1'b0;
      repeat (40) tick();

      // T5: 4 ch x 24 bit, 8-bit slices on u1
      u1_in_data  = {24'h123456, 24'hFFFFFF, 24'h000000, 24'hA1B2C3};
      u1_in_valid = 1'b1;
      @(negedge clk);
      u1_in_valid = 1'b0;
      chk("t5_latency_valid", u1_out_valid, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("t5_valid", u1_out_valid, 1);
         chk("t5_slice", u1_out_slice, t5_s[i]);
         chk("t5_ch", u1_out_ch, (i / 3));
         chk("t5_sof", u1_out_sof, (i == 0));
         chk("t5_eof", u1_out_eof, (i == 11));
      end
      @(negedge clk);
      chk("t5_after_valid", u1_out_valid, 0);
      chk("t5_overrun", u1_overrun, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tdm_slice_serializer
